// File: rtl/sat_pkg.sv
// Shared types and widths for the SAT datapath: clause/variable index widths,
// the BCP sequencer state encoding and the implication record.
package sat_pkg;

  localparam int NUM_CLAUSE   = 1023;
  localparam int NUM_VARIABLE = 128;

  localparam int ADDR_W  = $clog2(NUM_CLAUSE);
  localparam int COUNT_W = ADDR_W + 1;
  localparam int VAR_W   = $clog2(NUM_VARIABLE);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    FINISH
  } bcp_state_t;

  typedef struct packed {
    logic [VAR_W-1:0] variable;
    logic             value;
  } implication_t;

endpackage

// File: rtl/implication_fifo.sv
// Synchronous FIFO of implication records with flush; the head entry reads as
// zero while empty so the downstream payload is clean after reset and flush.
module implication_fifo
  import sat_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  implication_t               push_data,
  input  logic                       pop,
  output implication_t               pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  implication_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: the storage array is deliberately left without reset; only pointers
  // and count are reset, and the output mux below hides stale entries.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/bcp_scheduler.sv
// BCP scan sequencer: streams clause reads, buffers unit implications, repeats
// passes to fixpoint or conflict. Optional pass limit under BCP_PASS_LIMIT_EN.
module bcp_scheduler
  import sat_pkg::*;
#(
  parameter int IMPLY_DEPTH = 4,
  parameter int PASS_LIMIT  = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_clause,
  output logic               busy,
  output logic               done,
  output logic               conflict,
  output logic               timeout,
  output logic               clause_rd_en,
  output logic [ADDR_W-1:0]  clause_addr,
  input  logic               eval_valid,
  input  logic               eval_falsified,
  input  logic               eval_unit,
  input  logic [VAR_W-1:0]   eval_implied_variable,
  input  logic               eval_new_assignment,
  output logic               imply_valid,
  output logic [VAR_W-1:0]   imply_variable,
  output logic               imply_value,
  input  logic               imply_ready
);

  localparam int FC_W = $clog2(IMPLY_DEPTH) + 1;

  bcp_state_t         state;
  bcp_state_t         state_next;
  logic [COUNT_W-1:0] scan_idx;
  logic [COUNT_W-1:0] num_clause_q;
  logic               inflight;
  logic               progress;
  logic               conflict_q;

  logic               all_issued;
  logic               kill;
  logic               room;
  logic               push;
  logic               pop;
  logic               at_limit;

  implication_t       push_data;
  implication_t       head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FC_W-1:0]    fifo_count;

  assign all_issued = (scan_idx == num_clause_q);
  assign kill       = (state == SCAN) & eval_valid & eval_falsified;
  assign push       = (state == SCAN) & eval_valid & ~eval_falsified & eval_unit;
  assign pop        = imply_valid & imply_ready;

  // Throttle counts the read already in flight so its result always has a slot.
  assign room = ~fifo_full &
                ((int'(fifo_count) + int'(inflight)) < IMPLY_DEPTH);

  assign clause_rd_en = (state == SCAN) & ~all_issued & room & ~kill;
  assign clause_addr  = scan_idx[ADDR_W-1:0];
  assign busy         = (state != IDLE);
  assign done         = (state == FINISH);
  assign conflict     = conflict_q;

  assign push_data.variable = eval_implied_variable;
  assign push_data.value    = eval_new_assignment;

`ifdef BCP_PASS_LIMIT_EN
  localparam int PASS_W = $clog2(PASS_LIMIT + 1);

  logic [PASS_W-1:0] pass_cnt;
  logic              timeout_q;

  assign at_limit = (int'(pass_cnt) == PASS_LIMIT - 1);
  assign timeout  = timeout_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pass_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (state == IDLE && start) begin
      pass_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (state == DRAIN && state_next == SCAN) begin
      pass_cnt <= pass_cnt + 1'b1;
    end else if (state == DRAIN && state_next == FINISH && progress) begin
      timeout_q <= 1'b1;
    end
  end
`else
  logic unused_pass_limit;

  assign at_limit          = 1'b0;
  assign timeout           = 1'b0;
  assign unused_pass_limit = (PASS_LIMIT > 0);
`endif

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) state_next = (num_clause == '0) ? FINISH : SCAN;
      end
      SCAN: begin
        if (kill) state_next = FINISH;
        else if (all_issued && (eval_valid || !inflight)) state_next = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) state_next = (progress && !at_limit) ? SCAN : FINISH;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      scan_idx     <= '0;
      num_clause_q <= '0;
      inflight     <= 1'b0;
      progress     <= 1'b0;
      conflict_q   <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= clause_rd_en;
      if (state == IDLE && start) begin
        num_clause_q <= num_clause;
        scan_idx     <= '0;
        progress     <= 1'b0;
        conflict_q   <= 1'b0;
      end
      if (clause_rd_en) scan_idx <= scan_idx + 1'b1;
      if (push)         progress <= 1'b1;
      if (kill)         conflict_q <= 1'b1;
      if (state == DRAIN && state_next == SCAN) begin
        scan_idx <= '0;
        progress <= 1'b0;
      end
    end
  end

  implication_fifo #(
    .DEPTH(IMPLY_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (kill),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign imply_valid    = ~fifo_empty;
  assign imply_variable = head.variable;
  assign imply_value    = head.value;

endmodule
